// File: rtl/cenn_pkg.sv
// Shared types and constants for the CeNN front-end mask scan controller.
package cenn_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} scan_state_t;

  localparam int DRAIN_CYC = 2;
  localparam int MASK_FILL = 2;

endpackage

// File: rtl/scan_addr_gen.sv
// Raster counters and three row base addresses for the mask scan.
// Every base steps by one per issue, so the row wrap needs no multiplier.
module scan_addr_gen #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = $clog2(IMG_W*IMG_H),
  parameter int COL_W  = $clog2(IMG_W),
  parameter int ROW_W  = $clog2(IMG_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic              clear,
  output logic [COL_W-1:0]  c,
  output logic [ROW_W-1:0]  r,
  output logic              last,
  output logic [ADDR_W-1:0] rd_addr_1,
  output logic [ADDR_W-1:0] rd_addr_2,
  output logic [ADDR_W-1:0] rd_addr_3
);

  logic [COL_W-1:0]  c_q, c_d;
  logic [ROW_W-1:0]  r_q, r_d;
  logic [ADDR_W-1:0] base1_q, base1_d;
  logic [ADDR_W-1:0] base2_q, base2_d;
  logic [ADDR_W-1:0] base3_q, base3_d;

  logic col_end;
  assign col_end = (c_q == COL_W'(IMG_W-1));

  // NOTE: every _d signal gets its hold value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    c_d     = c_q;
    r_d     = r_q;
    base1_d = base1_q;
    base2_d = base2_q;
    base3_d = base3_q;
    if (clear) begin
      c_d     = '0;
      r_d     = '0;
      base3_d = '0;
      base2_d = ADDR_W'(IMG_W);
      base1_d = ADDR_W'(2*IMG_W);
    end else if (step) begin
      base1_d = base1_q + ADDR_W'(1);
      base2_d = base2_q + ADDR_W'(1);
      base3_d = base3_q + ADDR_W'(1);
      if (col_end) begin
        c_d = '0;
        r_d = r_q + ROW_W'(1);
      end else begin
        c_d = c_q + COL_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q     <= '0;
      r_q     <= '0;
      base1_q <= '0;
      base2_q <= '0;
      base3_q <= '0;
    end else begin
      c_q     <= c_d;
      r_q     <= r_d;
      base1_q <= base1_d;
      base2_q <= base2_d;
      base3_q <= base3_d;
    end
  end

  assign c         = c_q;
  assign r         = r_q;
  assign last      = col_end && (r_q == ROW_W'(IMG_H-3));
  assign rd_addr_1 = base1_q;
  assign rd_addr_2 = base2_q;
  assign rd_addr_3 = base3_q;

endmodule

// File: rtl/mask_scan_ctrl.sv
// Raster-scan sequencer for the CeNN 3x3 mask stage: read issue, window-valid alignment, start/done.
// Optional MASK_SCAN_PERF_EN adds a saturating stall_cnt of held SCAN cycles.
module mask_scan_ctrl
  import cenn_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = $clog2(IMG_W*IMG_H),
  parameter int CRD_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              hold,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_1,
  output logic [ADDR_W-1:0] rd_addr_2,
  output logic [ADDR_W-1:0] rd_addr_3,
  output logic              read_ready,
  output logic              win_valid,
  output logic [CRD_W-1:0]  win_row,
  output logic [CRD_W-1:0]  win_col,
  output logic              busy,
  output logic              done
`ifdef MASK_SCAN_PERF_EN
  , output logic [15:0]     stall_cnt
`endif
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  scan_state_t      state_q, state_d;
  logic [1:0]       drain_q, drain_d;
  logic             step, clear, last;
  logic [COL_W-1:0] c;
  logic [ROW_W-1:0] r;

  logic             rd_en_q;
  logic             vld1_q, vld1_d;
  logic [CRD_W-1:0] row1_q, row1_d, col1_q, col1_d;
  logic             win_valid_q;
  logic [CRD_W-1:0] win_row_q, win_row_d, win_col_q, win_col_d;

  scan_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (step),
    .clear    (clear),
    .c        (c),
    .r        (r),
    .last     (last),
    .rd_addr_1(rd_addr_1),
    .rd_addr_2(rd_addr_2),
    .rd_addr_3(rd_addr_3)
  );

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    step    = 1'b0;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = SCAN;
        clear   = 1'b1;
      end
      SCAN: if (!hold) begin
        step = 1'b1;
        if (last) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        if (drain_q == 2'(DRAIN_CYC-1)) state_d = DONE;
        else                            drain_d = drain_q + 2'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Window flag trails the issue by the memory latency plus the mask shift;
  // the column test drops windows still holding the previous row's pixels.
  always_comb begin
    vld1_d    = step && (c >= COL_W'(MASK_FILL));
    row1_d    = CRD_W'(r) + CRD_W'(1);
    col1_d    = CRD_W'(c) - CRD_W'(1);
    win_row_d = vld1_q ? row1_q : win_row_q;
    win_col_d = vld1_q ? col1_q : win_col_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      drain_q     <= '0;
      rd_en_q     <= 1'b0;
      vld1_q      <= 1'b0;
      row1_q      <= '0;
      col1_q      <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      rd_en_q     <= step;
      vld1_q      <= vld1_d;
      row1_q      <= row1_d;
      col1_q      <= col1_d;
      win_valid_q <= vld1_q;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

  assign rd_en      = step;
  assign read_ready = rd_en_q;
  assign win_valid  = win_valid_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign busy       = (state_q == SCAN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);

`ifdef MASK_SCAN_PERF_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (clear) stall_d = '0;
    else if ((state_q == SCAN) && hold && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mask_scan_ctrl.sv
// Randomized bench for mask_scan_ctrl: a 5x4 and a 3x3 instance checked cycle by cycle
// against an issue-schedule model derived from frame arithmetic.
module tb_mask_scan_ctrl;

  localparam int AW_A = $clog2(5*4);
  localparam int AW_B = $clog2(3*3);
  localparam int MAXC = 320;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, hold_a = 1'b0, start_b = 1'b0, hold_b = 1'b0;

  always #5 clk = ~clk;

  logic            a_rd, a_rr, a_wv, a_busy, a_done;
  logic [AW_A-1:0] a_a1, a_a2, a_a3;
  logic [7:0]      a_wr, a_wc;
  logic            b_rd, b_rr, b_wv, b_busy, b_done;
  logic [AW_B-1:0] b_a1, b_a2, b_a3;
  logic [7:0]      b_wr, b_wc;
`ifdef MASK_SCAN_PERF_EN
  logic [15:0]     a_st, b_st;
`endif

  mask_scan_ctrl #(.IMG_W(5), .IMG_H(4), .ADDR_W(AW_A), .CRD_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .hold(hold_a),
    .rd_en(a_rd), .rd_addr_1(a_a1), .rd_addr_2(a_a2), .rd_addr_3(a_a3),
    .read_ready(a_rr), .win_valid(a_wv), .win_row(a_wr), .win_col(a_wc),
    .busy(a_busy), .done(a_done)
`ifdef MASK_SCAN_PERF_EN
    , .stall_cnt(a_st)
`endif
  );

  mask_scan_ctrl #(.IMG_W(3), .IMG_H(3), .ADDR_W(AW_B), .CRD_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .hold(hold_b),
    .rd_en(b_rd), .rd_addr_1(b_a1), .rd_addr_2(b_a2), .rd_addr_3(b_a3),
    .read_ready(b_rr), .win_valid(b_wv), .win_row(b_wr), .win_col(b_wc),
    .busy(b_busy), .done(b_done)
`ifdef MASK_SCAN_PERF_EN
    , .stall_cnt(b_st)
`endif
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // Stimulus per cycle and expected outputs per cycle.
  bit st_v[MAXC];
  bit hd_v[MAXC];
  int e_rd[MAXC], e_a1[MAXC], e_a2[MAXC], e_a3[MAXC], e_ak[MAXC];
  int e_rr[MAXC], e_wv[MAXC], e_wr[MAXC], e_wc[MAXC];
  int e_busy[MAXC], e_done[MAXC], e_st[MAXC];
  bit wset[MAXC], sset[MAXC];

  int o_rd, o_a1, o_a2, o_a3, o_rr, o_wv, o_wr, o_wc, o_busy, o_done, o_st;

  task automatic sample(input bit sel);
    o_st = 0;
    if (sel) begin
      o_rd = int'(b_rd); o_a1 = int'(b_a1); o_a2 = int'(b_a2); o_a3 = int'(b_a3);
      o_rr = int'(b_rr); o_wv = int'(b_wv); o_wr = int'(b_wr); o_wc = int'(b_wc);
      o_busy = int'(b_busy); o_done = int'(b_done);
`ifdef MASK_SCAN_PERF_EN
      o_st = int'(b_st);
`endif
    end else begin
      o_rd = int'(a_rd); o_a1 = int'(a_a1); o_a2 = int'(a_a2); o_a3 = int'(a_a3);
      o_rr = int'(a_rr); o_wv = int'(a_wv); o_wr = int'(a_wr); o_wc = int'(a_wc);
      o_busy = int'(a_busy); o_done = int'(a_done);
`ifdef MASK_SCAN_PERF_EN
      o_st = int'(a_st);
`endif
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      st_v[i] = 1'b0;
      hd_v[i] = 1'b0;
    end
  endtask

  // Frame schedule: after an accepted start at s, the k-th issue lands on the
  // k-th un-held cycle after s; pixel k sits at row k/w, column k%w.
  task automatic build_model(input int w, input int h, input int n);
    int nis, t, tt, k, r, c;
    nis = (h-2)*w;
    for (int i = 0; i < MAXC; i++) begin
      e_rd[i] = 0; e_a1[i] = 0; e_a2[i] = 0; e_a3[i] = 0; e_ak[i] = 0;
      e_rr[i] = 0; e_wv[i] = 0; e_wr[i] = 0; e_wc[i] = 0;
      e_busy[i] = 0; e_done[i] = 0; e_st[i] = 0;
      wset[i] = 1'b0; sset[i] = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      e_ak[i] = 1;
      if (st_v[i]) break;
    end
    t = 0;
    while (t < n) begin
      if (!st_v[t]) begin
        t++;
      end else begin
        tt = t;
        k  = 0;
        e_st[t+1] = 0;
        sset[t+1] = 1'b1;
        while (k < nis && tt < MAXC-4) begin
          tt++;
          e_busy[tt] = 1;
          if (!hd_v[tt]) begin
            r = k / w;
            c = k % w;
            e_rd[tt] = 1; e_ak[tt] = 1;
            e_a3[tt] = k; e_a2[tt] = k + w; e_a1[tt] = k + 2*w;
            e_rr[tt+1] = 1;
            if (c >= 2) begin
              e_wv[tt+2] = 1; e_wr[tt+2] = r + 1; e_wc[tt+2] = c - 1;
              wset[tt+2] = 1'b1;
            end
            k++;
          end
          e_st[tt+1] = e_st[tt] + (hd_v[tt] ? 1 : 0);
          sset[tt+1] = 1'b1;
        end
        if (tt + 3 < MAXC) begin
          e_busy[tt+1] = 1;
          e_busy[tt+2] = 1;
          e_done[tt+3] = 1;
        end
        t = tt + 4;
      end
    end
    for (int i = 1; i < MAXC; i++) begin
      if (!wset[i]) begin
        e_wr[i] = e_wr[i-1];
        e_wc[i] = e_wc[i-1];
      end
      if (!sset[i]) e_st[i] = e_st[i-1];
    end
  endtask

  task automatic drive(input bit sel, input bit s, input bit h);
    start_a = sel ? 1'b0 : s;
    hold_a  = sel ? 1'b0 : h;
    start_b = sel ? s : 1'b0;
    hold_b  = sel ? h : 1'b0;
  endtask

  task automatic check_zero(input bit sel, input string tag);
    sample(sel);
    check({tag, "_rd_en"}, o_rd, 0);
    check({tag, "_addr1"}, o_a1, 0);
    check({tag, "_addr2"}, o_a2, 0);
    check({tag, "_addr3"}, o_a3, 0);
    check({tag, "_read_ready"}, o_rr, 0);
    check({tag, "_win_valid"}, o_wv, 0);
    check({tag, "_win_row"}, o_wr, 0);
    check({tag, "_win_col"}, o_wc, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
`ifdef MASK_SCAN_PERF_EN
    check({tag, "_stall_cnt"}, o_st, 0);
`endif
  endtask

  // Entered with rst_n low; returns with rst_n low.
  task automatic run_seg(input bit sel, input int w, input int h, input int n,
                         input int abort_at, output int wins, output int dones);
    string p;
    wins  = 0;
    dones = 0;
    build_model(w, h, n);
    @(negedge clk);
    check_zero(sel, "in_reset");
    rst_n = 1'b1;
    for (int t = 0; t < n; t++) begin
      @(posedge clk);
      #1;
      drive(sel, st_v[t], hd_v[t]);
      if (t == abort_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_zero(sel, $sformatf("abort@%0d", t));
        drive(sel, 1'b0, 1'b0);
        return;
      end
      @(negedge clk);
      sample(sel);
      p = $sformatf("%s@%0d", sel ? "b" : "a", t);
      check({p, "_rd_en"}, o_rd, e_rd[t]);
      if (e_ak[t] != 0) begin
        check({p, "_addr1"}, o_a1, e_a1[t]);
        check({p, "_addr2"}, o_a2, e_a2[t]);
        check({p, "_addr3"}, o_a3, e_a3[t]);
      end
      check({p, "_read_ready"}, o_rr, e_rr[t]);
      check({p, "_win_valid"}, o_wv, e_wv[t]);
      check({p, "_win_row"}, o_wr, e_wr[t]);
      check({p, "_win_col"}, o_wc, e_wc[t]);
      check({p, "_busy"}, o_busy, e_busy[t]);
      check({p, "_done"}, o_done, e_done[t]);
`ifdef MASK_SCAN_PERF_EN
      check({p, "_stall_cnt"}, o_st, e_st[t]);
`endif
      wins  += o_wv;
      dones += o_done;
    end
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
  endtask

  initial begin
    int ws, ds;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);

    // Plain frame with starts while busy and a back-to-back start after done.
    clear_stim();
    st_v[0] = 1'b1; st_v[4] = 1'b1; st_v[9] = 1'b1; st_v[14] = 1'b1;
    run_seg(1'b0, 5, 4, 40, -1, ws, ds);
    check("frames2_windows", ws, 12);
    check("frames2_dones", ds, 2);

    // Hold during cycles 3-4 shifts the schedule by two cycles.
    clear_stim();
    st_v[0] = 1'b1; hd_v[3] = 1'b1; hd_v[4] = 1'b1;
    run_seg(1'b0, 5, 4, 20, -1, ws, ds);
    check("hold_windows", ws, 6);
    check("hold_dones", ds, 1);

    // Reset mid-frame, then a quiet period with no start.
    clear_stim();
    st_v[0] = 1'b1;
    run_seg(1'b0, 5, 4, 20, 6, ws, ds);
    clear_stim();
    run_seg(1'b0, 5, 4, 20, -1, ws, ds);
    check("idle_windows", ws, 0);
    check("idle_dones", ds, 0);

    // start and hold together in IDLE.
    clear_stim();
    st_v[0] = 1'b1;
    for (int i = 0; i < 4; i++) hd_v[i] = 1'b1;
    run_seg(1'b0, 5, 4, 25, -1, ws, ds);
    check("start_hold_windows", ws, 6);

    // Random starts and back-pressure on the 5x4 frame.
    clear_stim();
    for (int i = 0; i < 240; i++) begin
      st_v[i] = ($urandom_range(0, 9) == 0);
      hd_v[i] = ($urandom_range(0, 3) == 0);
    end
    run_seg(1'b0, 5, 4, 240, -1, ws, ds);

    // Minimal 3x3 frame: one window at (1,1).
    clear_stim();
    st_v[0] = 1'b1;
    run_seg(1'b1, 3, 3, 10, -1, ws, ds);
    check("min_windows", ws, 1);
    check("min_dones", ds, 1);

    // Random traffic on the 3x3 frame.
    clear_stim();
    for (int i = 0; i < 150; i++) begin
      st_v[i] = ($urandom_range(0, 5) == 0);
      hd_v[i] = ($urandom_range(0, 2) == 0);
    end
    run_seg(1'b1, 3, 3, 150, -1, ws, ds);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
